// File: rtl/bitpack_store_pkg.sv
// Shared constants, types and FSM encoding for the bit-packing byte store.
package bitpack_store_pkg;

   localparam int STORE_MEMSIZE       = 2048;
   localparam int STORE_MAX_CODE_BITS = 20;
   localparam int STORE_LW            = $clog2(STORE_MAX_CODE_BITS + 1);

   typedef logic [STORE_LW-1:0] code_len_t;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      FLUSH = 2'd1,
      DONE  = 2'd2
   } bitpack_state_e;

endpackage

// File: rtl/bitpack_store_bram.sv
// Simple dual-port byte RAM: one write port, registered read-first read port.
module bram_sdp_byte
   import bitpack_store_pkg::*;
#(
   parameter  int DEPTH = STORE_MEMSIZE,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] wr_addr,
   input  logic [7:0]    wr_data,
   input  logic [AW-1:0] rd_addr,
   output logic [7:0]    rd_data
);

   (* ram_style = "block" *) logic [7:0] mem [DEPTH];

   // Read and write share one process so a same-address access returns the old byte.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[wr_addr] <= wr_data;
      end
      rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/bitpack_store.sv
// Packs variable-length codewords LSB-first and drains whole bytes into a byte RAM.
// Optional statistics counters are enabled by defining BITPACK_STORE_STATS_EN.
module bitpack_store
   import bitpack_store_pkg::*;
#(
   parameter  int MAX_CODE_BITS = STORE_MAX_CODE_BITS,
   parameter  int BUF_BITS      = 40,
   parameter  int MEMSIZE       = STORE_MEMSIZE,
   parameter  int RING_MODE     = 0,
   localparam int LW            = $clog2(MAX_CODE_BITS + 1),
   localparam int AW            = $clog2(MEMSIZE)
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     code_valid,
   output logic                     code_ready,
   input  logic [MAX_CODE_BITS-1:0] code_data,
   input  logic [LW-1:0]            code_len,
   input  logic                     flush,
   output logic                     flush_done,
   output logic [AW:0]              wr_count,
   output logic                     full,
   output logic                     wrapped,
   output logic                     overflow,
   input  logic [AW-1:0]            rd_addr,
   output logic [7:0]               rd_data
`ifdef BITPACK_STORE_STATS_EN
   ,
   output logic [31:0]              codes_accepted,
   output logic [31:0]              bits_accepted
`endif
);

   localparam int           CW          = $clog2(BUF_BITS + 1);
   localparam int           READY_LIMIT = BUF_BITS - MAX_CODE_BITS;
   localparam logic [AW:0]  COUNT_MAX   = (AW+1)'(MEMSIZE);
   localparam logic [AW:0]  COUNT_LAST  = (AW+1)'(MEMSIZE - 1);

   bitpack_state_e          state;
   logic [BUF_BITS-1:0]     bit_buf;
   logic [CW-1:0]           bit_count;
   logic [AW-1:0]           wr_ptr;

   logic [MAX_CODE_BITS-1:0] len_mask;
   logic                     accept;
   logic                     can_write;
   logic                     drain;
   logic                     pad_write;
   logic                     wr_en;
   logic [CW-1:0]            reduced_count;
   logic [BUF_BITS-1:0]      shifted_buf;
   logic [BUF_BITS-1:0]      code_ext;
   logic [BUF_BITS-1:0]      next_buf;
   logic [CW-1:0]            next_count;

   // Bits at or above code_len never reach the buffer, so padding is always zero.
   for (genvar gi = 0; gi < MAX_CODE_BITS; gi++) begin : g_mask
      assign len_mask[gi] = (int'(code_len) > gi);
   end

   assign code_ready = (state == RUN) && (bit_count <= CW'(READY_LIMIT)) && !full;
   assign accept     = code_valid && code_ready;
   assign can_write  = (RING_MODE != 0) || !full;
   assign drain      = (bit_count >= CW'(8)) && can_write;
   assign pad_write  = (state == FLUSH) && can_write &&
                       (bit_count != '0) && (bit_count < CW'(8));
   assign wr_en      = drain || pad_write;

   always_comb begin
      reduced_count = bit_count;
      shifted_buf   = bit_buf;
      if (drain) begin
         reduced_count = bit_count - CW'(8);
         shifted_buf   = bit_buf >> 8;
      end
      code_ext   = BUF_BITS'(code_data & len_mask);
      next_buf   = shifted_buf;
      next_count = reduced_count;
      if (accept) begin
         next_buf   = shifted_buf | (code_ext << reduced_count);
         next_count = reduced_count + CW'(code_len);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= RUN;
         bit_buf    <= '0;
         bit_count  <= '0;
         wr_ptr     <= '0;
         wr_count   <= '0;
         full       <= 1'b0;
         wrapped    <= 1'b0;
         overflow   <= 1'b0;
         flush_done <= 1'b0;
      end else begin
         bit_buf    <= next_buf;
         bit_count  <= next_count;
         flush_done <= 1'b0;

         if (wr_en) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (wr_count != COUNT_MAX) begin
               wr_count <= wr_count + 1'b1;
            end
            if ((RING_MODE == 0) && (wr_count == COUNT_LAST)) begin
               full <= 1'b1;
            end
            // A write while the count is saturated can only land on an old byte.
            if ((RING_MODE != 0) && (wr_count == COUNT_MAX)) begin
               wrapped <= 1'b1;
            end
         end

         if (code_valid && full) begin
            overflow <= 1'b1;
         end

         case (state)
            RUN: begin
               if (flush) begin
                  state <= FLUSH;
               end
            end
            FLUSH: begin
               if (!can_write) begin
                  bit_buf    <= '0;
                  bit_count  <= '0;
                  if (bit_count != '0) begin
                     overflow <= 1'b1;
                  end
                  state      <= DONE;
                  flush_done <= 1'b1;
               end else if (bit_count == '0) begin
                  state      <= DONE;
                  flush_done <= 1'b1;
               end else if (bit_count < CW'(8)) begin
                  bit_buf    <= '0;
                  bit_count  <= '0;
                  state      <= DONE;
                  flush_done <= 1'b1;
               end
            end
            DONE: begin
               state <= RUN;
            end
            default: begin
               state <= RUN;
            end
         endcase
      end
   end

`ifdef BITPACK_STORE_STATS_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         codes_accepted <= '0;
         bits_accepted  <= '0;
      end else if (accept) begin
         codes_accepted <= codes_accepted + 32'd1;
         bits_accepted  <= bits_accepted + 32'(code_len);
      end
   end
`endif

   bram_sdp_byte #(
      .DEPTH (MEMSIZE)
   ) u_ram (
      .clk     (clk),
      .we      (wr_en),
      .wr_addr (wr_ptr),
      .wr_data (bit_buf[7:0]),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

endmodule

// File: tb/tb_bitpack_store.sv
// Randomised scoreboard bench: a stop-mode and a ring-mode store, both 16 bytes deep.
`timescale 1ns/1ps
module tb_bitpack_store;
   import bitpack_store_pkg::*;

   localparam int MCB = 20;
   localparam int MS  = 16;
   localparam int AW  = 4;

   logic             clk = 1'b0;
   always #5 clk = ~clk;

   logic             reset_n    [2];
   logic             code_valid [2];
   logic             code_ready [2];
   logic [MCB-1:0]   code_data  [2];
   code_len_t        code_len   [2];
   logic             flush      [2];
   logic             flush_done [2];
   logic [AW:0]      wr_count   [2];
   logic             full       [2];
   logic             wrapped    [2];
   logic             overflow   [2];
   logic [AW-1:0]    rd_addr    [2];
   logic [7:0]       rd_data    [2];
`ifdef BITPACK_STORE_STATS_EN
   logic [31:0]      codes_acc  [2];
   logic [31:0]      bits_acc   [2];
`endif

   for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      bitpack_store #(
         .MAX_CODE_BITS (MCB),
         .BUF_BITS      (40),
         .MEMSIZE       (MS),
         .RING_MODE     (gi)
      ) u_dut (
         .clk        (clk),
         .reset_n    (reset_n[gi]),
         .code_valid (code_valid[gi]),
         .code_ready (code_ready[gi]),
         .code_data  (code_data[gi]),
         .code_len   (code_len[gi]),
         .flush      (flush[gi]),
         .flush_done (flush_done[gi]),
         .wr_count   (wr_count[gi]),
         .full       (full[gi]),
         .wrapped    (wrapped[gi]),
         .overflow   (overflow[gi]),
         .rd_addr    (rd_addr[gi]),
         .rd_data    (rd_data[gi])
`ifdef BITPACK_STORE_STATS_EN
         ,
         .codes_accepted (codes_acc[gi]),
         .bits_accepted  (bits_acc[gi])
`endif
      );
   end

   // Reference model: a plain bit stream turned into bytes, plus a RAM image per DUT.
   bit          bitq [$];
   logic [7:0]  mem_m [2][MS];
   int          wptr_m, cnt_m;
   int          acc_codes, acc_bits;
   int          flush_cnt [2];
   int          n_checks = 0;
   int          n_pass   = 0;
   bit          ready_dropped;

   typedef struct {
      int         dut;
      int         addr;
      logic [7:0] val;
   } rd_exp_t;
   rd_exp_t     exp_q [$];
   bit          rd_req = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   function automatic void model_reset();
      bitq.delete();
      wptr_m    = 0;
      cnt_m     = 0;
      acc_codes = 0;
      acc_bits  = 0;
   endfunction

   function automatic void model_drain(input int d);
      logic [7:0] b;
      while (bitq.size() >= 8) begin
         if (d == 0 && cnt_m == MS) break;
         for (int i = 0; i < 8; i++) b[i] = bitq.pop_front();
         mem_m[d][wptr_m] = b;
         wptr_m = (wptr_m + 1) % MS;
         if (cnt_m < MS) cnt_m++;
      end
   endfunction

   function automatic void model_push(input int d, input logic [MCB-1:0] data, input int len);
      for (int i = 0; i < len; i++) bitq.push_back(data[i]);
      acc_codes++;
      acc_bits += len;
      model_drain(d);
   endfunction

   function automatic void model_flush(input int d);
      model_drain(d);
      if (d == 0 && cnt_m == MS) bitq.delete();
      else if (bitq.size() > 0) begin
         while (bitq.size() < 8) bitq.push_back(1'b0);
         model_drain(d);
      end
   endfunction

   // Monitor: compares read data one cycle after each issued read, counts flush_done pulses.
   initial begin : monitor
      bit      pend;
      rd_exp_t e;
      forever begin
         @(posedge clk);
         pend = rd_req;
         @(negedge clk);
         if (pend) begin
            if (exp_q.size() == 0) chk("rd_unexpected", 1, 0);
            else begin
               e = exp_q.pop_front();
               chk($sformatf("rd_d%0d_a%0d", e.dut, e.addr), int'(rd_data[e.dut]), int'(e.val));
            end
         end
         for (int d = 0; d < 2; d++) if (flush_done[d]) flush_cnt[d]++;
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   // All stimulus tasks start and end just after a falling edge.
   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset(input int d);
      @(negedge clk);
      reset_n[d] = 1'b0; code_valid[d] = 1'b0; flush[d] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset_n[d] = 1'b1;
      model_reset();
   endtask

   task automatic send(input int d, input logic [MCB-1:0] data, input int len, input bit keep);
      bit rdy;
      code_valid[d] = 1'b1; code_data[d] = data; code_len[d] = code_len_t'(len);
      for (int t = 0; t < 64; t++) begin
         rdy = code_ready[d];
         if (!rdy) ready_dropped = 1'b1;
         @(posedge clk);
         if (rdy) begin
            model_push(d, data, len);
            @(negedge clk);
            if (!keep) code_valid[d] = 1'b0;
            return;
         end
         @(negedge clk);
      end
      chk("send_timeout", 0, 1);
      code_valid[d] = 1'b0;
   endtask

   task automatic do_flush(input int d);
      flush[d] = 1'b1;
      @(negedge clk);
      flush[d] = 1'b0;
      model_flush(d);
   endtask

   task automatic read_check(input int d, input int addr);
      rd_addr[d] = addr[AW-1:0];
      rd_req = 1'b1;
      exp_q.push_back('{dut: d, addr: addr, val: mem_m[d][addr]});
      @(negedge clk);
      rd_req = 1'b0;
      @(negedge clk);
   endtask

   task automatic read_all(input int d, input int n);
      for (int a = 0; a < n; a++) read_check(d, a);
   endtask

   task automatic check_reset_vals(input int d, input string tag);
      chk({tag, "_code_ready"}, int'(code_ready[d]), 1);
      chk({tag, "_wr_count"},   int'(wr_count[d]), 0);
      chk({tag, "_full"},       int'(full[d]), 0);
      chk({tag, "_wrapped"},    int'(wrapped[d]), 0);
      chk({tag, "_overflow"},   int'(overflow[d]), 0);
      chk({tag, "_flush_done"}, int'(flush_done[d]), 0);
   endtask

   initial begin : stim
      int             fb;
      int             len;
      bit             rdy;
      logic [MCB-1:0] data;
      logic [7:0]     b;

      for (int d = 0; d < 2; d++) begin
         reset_n[d] = 1'b0; code_valid[d] = 1'b0; code_data[d] = '0;
         code_len[d] = '0; flush[d] = 1'b0; rd_addr[d] = '0; flush_cnt[d] = 0;
      end

      // Reset state of both variants.
      do_reset(0);
      do_reset(1);
      check_reset_vals(0, "rst_stop");
      check_reset_vals(1, "rst_ring");

      // Two whole bytes, no flush.
      do_reset(0);
      fb = flush_cnt[0];
      send(0, 20'hA5, 8, 1'b1);
      send(0, 20'h3C, 8, 1'b0);
      idle(4);
      chk("a_wr_count", int'(wr_count[0]), 2);
      chk("a_flush_pulses", flush_cnt[0] - fb, 0);
      chk("a_overflow", int'(overflow[0]), 0);
      read_all(0, 2);

      // 20-bit word then flush pads the last byte.
      do_reset(0);
      fb = flush_cnt[0];
      send(0, 20'hABCDE, 20, 1'b0);
      do_flush(0);
      idle(6);
      chk("b_wr_count", int'(wr_count[0]), 3);
      chk("b_flush_pulses", flush_cnt[0] - fb, 1);
      chk("b_code_ready", int'(code_ready[0]), 1);
      chk("b_byte2_padded", int'(mem_m[0][2]), 'h0A);
      read_all(0, 3);

      // Back-to-back 20-bit words: throttling must not lose data.
      do_reset(0);
      ready_dropped = 1'b0;
      for (int i = 0; i < 5; i++) begin
         data = MCB'($urandom());
         send(0, data, 20, i != 4);
      end
      do_flush(0);
      idle(8);
      chk("c_ready_dropped", int'(ready_dropped), 1);
      chk("c_wr_count", int'(wr_count[0]), 13);
      read_all(0, 13);

      // Stop mode: overfill with random lengths (including zero-length no-ops).
      do_reset(0);
      data = MCB'($urandom()); len = $urandom_range(0, 20);
      for (int t = 0; t < 80; t++) begin
         code_valid[0] = 1'b1; code_data[0] = data; code_len[0] = code_len_t'(len);
         rdy = code_ready[0];
         @(posedge clk);
         if (rdy) begin
            model_push(0, data, len);
            data = MCB'($urandom()); len = $urandom_range(0, 20);
         end
         @(negedge clk);
      end
      code_valid[0] = 1'b0;
      idle(4);
      chk("d_full", int'(full[0]), 1);
      chk("d_code_ready", int'(code_ready[0]), 0);
      chk("d_overflow", int'(overflow[0]), 1);
      chk("d_wr_count", int'(wr_count[0]), MS);
      fb = flush_cnt[0];
      do_flush(0);
      idle(6);
      chk("d_flush_pulses", flush_cnt[0] - fb, 1);
      chk("d_full_after_flush", int'(full[0]), 1);
      read_all(0, MS);

      // Ring mode: exactly 16 bytes must not report a wrap; 20 bytes must.
      do_reset(1);
      for (int i = 0; i < 16; i++) send(1, MCB'($urandom_range(0, 255)), 8, 1'b1);
      code_valid[1] = 1'b0;
      idle(4);
      chk("e_wrapped_at_16", int'(wrapped[1]), 0);
      chk("e_wr_count_16", int'(wr_count[1]), MS);
      for (int i = 0; i < 4; i++) send(1, MCB'($urandom_range(0, 255)), 8, i != 3);
      idle(4);
      chk("e_wrapped_at_20", int'(wrapped[1]), 1);
      chk("e_wr_count_sat", int'(wr_count[1]), MS);
      chk("e_full", int'(full[1]), 0);
      read_all(1, MS);

      // Ring mode: random lengths wrapping repeatedly, then flush.
      for (int i = 0; i < 30; i++) begin
         len = $urandom_range(1, 20);
         send(1, MCB'($urandom()), len, i != 29);
      end
      fb = flush_cnt[1];
      do_flush(1);
      idle(8);
      chk("e2_flush_pulses", flush_cnt[1] - fb, 1);
      chk("e2_overflow", int'(overflow[1]), 0);
`ifdef BITPACK_STORE_STATS_EN
      chk("e2_codes_accepted", int'(codes_acc[1]), acc_codes);
      chk("e2_bits_accepted", int'(bits_acc[1]), acc_bits);
`endif
      read_all(1, MS);

      // Reset mid-flush with 5 bits pending; accept and flush in the same cycle.
      do_reset(0);
      fb = flush_cnt[0];
      code_valid[0] = 1'b1; code_data[0] = MCB'($urandom()); code_len[0] = code_len_t'(5);
      flush[0] = 1'b1;
      @(negedge clk);
      code_valid[0] = 1'b0; flush[0] = 1'b0;
      reset_n[0] = 1'b0;
      #1;
      check_reset_vals(0, "f_in_reset");
      idle(2);
      reset_n[0] = 1'b1;
      model_reset();
      b = ~mem_m[0][0];
      send(0, MCB'(b), 8, 1'b0);
      idle(4);
      chk("f_flush_pulses", flush_cnt[0] - fb, 0);
      chk("f_wr_count", int'(wr_count[0]), 1);
      read_all(0, 2);

      idle(4);
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
